// File: rtl/ov7670_config_sequencer.sv
// Walks a {regi,value} config table into i2c_sender, decoding end (FFFF) and delay (FFF0) markers.
// Advances one entry per synchronised rising edge of taken; flags done/error to the top level.
module ov7670_config_sequencer #(
  parameter logic [7:0] DEV_ID       = 8'h42,
  parameter int         ADDR_W       = 8,
  parameter int         DELAY_CYCLES = 250_000,
  parameter int         TIMEOUT      = 1_000_000,
  parameter bit         AUTO_START   = 1'b1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [15:0]       rom_data_i,
  output logic              send_o,
  output logic [7:0]        id_o,
  output logic [7:0]        regi_o,
  output logic [7:0]        value_o,
  input  logic              taken_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o
);

  localparam int DLY_W = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [DLY_W-1:0]  DLY_LOAD  = DLY_W'(DELAY_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [15:0]       END_MARK  = 16'hFFFF;
  localparam logic [15:0]       DLY_MARK  = 16'hFFF0;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_SEND, S_DELAY, S_DONE
  } state_t;

  localparam state_t RST_STATE = AUTO_START ? S_FETCH : S_IDLE;

  state_t             state_q, state_d;
  logic               taken_s1_q, taken_s2_q, taken_q;
  logic               taken_rise;
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  logic [7:0]         regi_q, regi_d;
  logic [7:0]         value_q, value_d;
  logic [DLY_W-1:0]   dly_cnt_q, dly_cnt_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               send_q, send_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic               at_last, to_expired, dly_zero;

  // taken comes from the slow SCCB clock domain; only its synchronised rising edge counts
  assign taken_rise = taken_s2_q & ~taken_q;
  assign at_last    = (rom_addr_q == ADDR_LAST);
  assign to_expired = (to_cnt_q == TO_LAST);
  assign dly_zero   = (dly_cnt_q == '0);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= RST_STATE;
      taken_s1_q <= 1'b0;
      taken_s2_q <= 1'b0;
      taken_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      taken_s1_q <= taken_i;
      taken_s2_q <= taken_s1_q;
      taken_q    <= taken_s2_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_i) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (rom_data_i == END_MARK)      state_d = S_DONE;
        else if (rom_data_i == DLY_MARK) state_d = S_DELAY;
        else                             state_d = S_SEND;
      end
      S_SEND: begin
        if (taken_rise)      state_d = at_last ? S_DONE : S_FETCH;
        else if (to_expired) state_d = S_DONE;
      end
      S_DELAY:  if (dly_zero) state_d = at_last ? S_DONE : S_FETCH;
      S_DONE:   if (start_i) state_d = S_FETCH;
      default:  state_d = RST_STATE;
    endcase
  end

  // Status outputs are registered from the next state so they read 0 while reset is held
  always_comb begin
    send_d = (state_d == S_SEND);
    busy_d = (state_d == S_FETCH) || (state_d == S_DECODE) ||
             (state_d == S_SEND)  || (state_d == S_DELAY);
    done_d = (state_d == S_DONE);
  end

  always_comb begin
    rom_addr_d = rom_addr_q;
    regi_d     = regi_q;
    value_d    = value_q;
    dly_cnt_d  = dly_cnt_q;
    to_cnt_d   = to_cnt_q;
    error_d    = error_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          rom_addr_d = '0;
          error_d    = 1'b0;
        end
      end
      S_DECODE: begin
        if (rom_data_i == DLY_MARK) begin
          dly_cnt_d = DLY_LOAD;
        end else if (rom_data_i != END_MARK) begin
          regi_d   = rom_data_i[15:8];
          value_d  = rom_data_i[7:0];
          to_cnt_d = '0;
        end
      end
      S_SEND: begin
        // a rise on the final timeout cycle still counts as an accepted write
        if (taken_rise) begin
          if (!at_last) rom_addr_d = rom_addr_q + 1'b1;
        end else if (to_expired) begin
          error_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_DELAY: begin
        if (dly_zero) begin
          if (!at_last) rom_addr_d = rom_addr_q + 1'b1;
        end else begin
          dly_cnt_d = dly_cnt_q - 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rom_addr_q <= '0;
      regi_q     <= '0;
      value_q    <= '0;
      dly_cnt_q  <= '0;
      to_cnt_q   <= '0;
      send_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      rom_addr_q <= rom_addr_d;
      regi_q     <= regi_d;
      value_q    <= value_d;
      dly_cnt_q  <= dly_cnt_d;
      to_cnt_q   <= to_cnt_d;
      send_q     <= send_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign rom_addr_o = rom_addr_q;
  assign send_o     = send_q;
  assign id_o       = DEV_ID;
  assign regi_o     = regi_q;
  assign value_o    = value_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign error_o    = error_q;

endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// Scoreboarded bench: table walks are predicted from the table contents, a taken responder
// answers each send, and a monitor checks every write, entry gap, timeout and status.
module tb_ov7670_config_sequencer;

  localparam int          ADDR_W = 3;
  localparam int          DEPTH  = 1 << ADDR_W;
  localparam int          DLY    = 100;
  localparam int          TMO    = 1000;
  localparam logic [7:0]  DEV    = 8'h42;

  logic              clk = 1'b0;
  logic              reset, start, taken;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_data;
  logic              send, busy, done, error;
  logic [7:0]        id, regi, value;
  logic [15:0]       tbl [DEPTH];

  typedef struct {
    logic [7:0] regi;
    logic [7:0] value;
    int         ndly;
    bit         tmo;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0, n_fail = 0;
  int   exp_addr, n_exp;
  bit   exp_error;
  int   cyc = 0;
  int   sends_seen, sends_fallen, taken_rises, responded, last_rise_cyc;
  bit   have_cur;
  bit   abort;
  bit   tk_enable;
  int   tk_dmin, tk_dmax, tk_hmin, tk_hmax;

  ov7670_config_sequencer #(
    .DEV_ID(DEV), .ADDR_W(ADDR_W), .DELAY_CYCLES(DLY), .TIMEOUT(TMO), .AUTO_START(1'b1)
  ) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .rom_addr_o(rom_addr),
    .rom_data_i(rom_data), .send_o(send), .id_o(id), .regi_o(regi), .value_o(value),
    .taken_i(taken), .busy_o(busy), .done_o(done), .error_o(error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= tbl[rom_addr];

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic logic [15:0] rnd_write();
    logic [15:0] w;
    w = 16'($urandom);
    while (w == 16'hFFFF || w == 16'hFFF0) w = 16'($urandom);
    return w;
  endfunction

  // Reference: scan the table; FFFF ends, FFF0 adds a delay before the next write,
  // anything else is one write. In timeout mode the first write never completes.
  task automatic build_model(input bit tmo_mode);
    int   ndly;
    bit   stop;
    exp_t e;
    ndly = 0;
    stop = 0;
    exp_q.delete();
    exp_error = 0;
    exp_addr  = DEPTH - 1;
    n_exp     = 0;
    for (int a = 0; a < DEPTH && !stop; a++) begin
      if (tbl[a] == 16'hFFFF) begin
        exp_addr = a;
        stop = 1;
      end else if (tbl[a] == 16'hFFF0) begin
        ndly++;
      end else begin
        e.regi  = tbl[a][15:8];
        e.value = tbl[a][7:0];
        e.ndly  = ndly;
        e.tmo   = tmo_mode;
        exp_q.push_back(e);
        n_exp++;
        ndly = 0;
        if (tmo_mode) begin
          exp_addr  = a;
          exp_error = 1;
          stop      = 1;
        end
      end
    end
  endtask

  task automatic prep_run(input bit tmo_mode);
    abort = 1;
    repeat (3) @(negedge clk);
    sends_seen    = 0;
    sends_fallen  = 0;
    taken_rises   = 0;
    responded     = 0;
    last_rise_cyc = -1;
    have_cur      = 0;
    build_model(tmo_mode);
    abort = 0;
  endtask

  task automatic pulse_start(input bit lat);
    start = 1;
    @(negedge clk);
    start = 0;
    if (lat) begin
      chk("start_busy", int'(busy), 1);
      chk("start_done_clr", int'(done), 0);
      chk("start_err_clr", int'(error), 0);
      chk("start_addr0", int'(rom_addr), 0);
      chk("lat_n1_send", int'(send), 0);
      @(negedge clk);
      chk("lat_n2_send", int'(send), 0);
      @(negedge clk);
      chk("lat_n3_send", int'(send), 1);
    end
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (!(done && !busy) && k < 20000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20000) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_wait: done never reached within 20000 cycles (busy=%0d)", name, busy);
    end
    @(negedge clk);
    chk($sformatf("%s_done", name), int'(done), 1);
    chk($sformatf("%s_busy", name), int'(busy), 0);
    chk($sformatf("%s_error", name), int'(error), int'(exp_error));
    chk($sformatf("%s_addr", name), int'(rom_addr), exp_addr);
    chk($sformatf("%s_send", name), int'(send), 0);
    chk($sformatf("%s_writes", name), sends_seen, n_exp);
    chk($sformatf("%s_leftover", name), exp_q.size(), 0);
  endtask

  // taken responder: one pulse per observed send, after a random delay
  initial begin
    int d, h;
    taken = 1'b0;
    forever begin
      @(negedge clk);
      if (abort) begin
        taken = 1'b0;
      end else if (tk_enable && responded < sends_seen) begin
        responded++;
        d = int'($urandom_range(tk_dmax, tk_dmin));
        for (int i = 0; i < d && !abort; i++) @(negedge clk);
        if (!abort) begin
          taken = 1'b1;
          taken_rises++;
          last_rise_cyc = cyc;
          h = int'($urandom_range(tk_hmax, tk_hmin));
          for (int i = 0; i < h && !abort; i++) @(negedge clk);
        end
        taken = 1'b0;
      end
    end
  end

  // monitor: pops the scoreboard on each send rise, checks completion on each send fall
  initial begin
    bit   prev;
    int   send_start;
    exp_t cur;
    prev = 0;
    send_start = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!abort) begin
        if (send && !prev) begin
          sends_seen++;
          send_start = cyc;
          chk("send_id", int'(id), int'(DEV));
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            have_cur = 0;
            $display("FAIL unexpected_send: regi 0x%0h value 0x%0h, no write expected", regi, value);
          end else begin
            cur = exp_q.pop_front();
            have_cur = 1;
            chk("send_regi", int'(regi), int'(cur.regi));
            chk("send_value", int'(value), int'(cur.value));
            if (last_rise_cyc >= 0)
              chk_range("entry_gap", cyc - last_rise_cyc, cur.ndly * DLY, cur.ndly * (DLY + 4) + 10);
          end
        end
        if (!send && prev && have_cur) begin
          sends_fallen++;
          chk("hold_regi", int'(regi), int'(cur.regi));
          chk("hold_value", int'(value), int'(cur.value));
          if (cur.tmo) chk("timeout_len", cyc - send_start, TMO);
          else         chk("one_entry_per_rise", sends_fallen, taken_rises);
          have_cur = 0;
        end
      end
      prev = send;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    bit wr0;
    reset = 1; start = 0; abort = 1; tk_enable = 1;
    tk_dmin = 128; tk_dmax = 128; tk_hmin = 4; tk_hmax = 4;
    foreach (tbl[i]) tbl[i] = 16'hFFFF;
    tbl[0] = 16'h1280; tbl[1] = 16'h1101; tbl[2] = 16'hFFFF;
    repeat (3) @(negedge clk);
    chk("rst_send", int'(send), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_regi", int'(regi), 0);
    chk("rst_value", int'(value), 0);
    chk("rst_addr", int'(rom_addr), 0);
    chk("rst_id", int'(id), int'(DEV));

    // basic two-write table, walk started by reset release
    prep_run(0);
    reset = 0;
    wait_done("t1_basic");

    // delay marker between two writes
    tk_dmin = 5; tk_dmax = 30;
    foreach (tbl[i]) tbl[i] = 16'hFFFF;
    tbl[0] = 16'h1280; tbl[1] = 16'hFFF0; tbl[2] = 16'h1101;
    prep_run(0);
    pulse_start(1);
    wait_done("t2_delay");

    // taken held high for 500 cycles
    tk_hmin = 500; tk_hmax = 500;
    foreach (tbl[i]) tbl[i] = 16'hFFFF;
    tbl[0] = 16'h1280; tbl[1] = 16'h1101; tbl[2] = 16'h1355;
    prep_run(0);
    pulse_start(1);
    wait_done("t3_hold");
    tk_hmin = 1; tk_hmax = 20;

    // taken never comes: timeout, then start clears error
    tk_enable = 0;
    foreach (tbl[i]) tbl[i] = 16'hFFFF;
    tbl[0] = 16'h1280; tbl[1] = 16'h1101;
    prep_run(1);
    pulse_start(1);
    wait_done("t4_timeout");
    tk_enable = 1;
    prep_run(0);
    pulse_start(1);
    wait_done("t4_restart");

    // full table with no end marker: stops at last address
    foreach (tbl[i]) tbl[i] = rnd_write();
    prep_run(0);
    pulse_start(1);
    wait_done("t5_noend");

    // randomized tables
    tk_dmin = 1; tk_dmax = 40;
    for (int r = 0; r < 6; r++) begin
      foreach (tbl[i]) begin
        k = int'($urandom_range(99, 0));
        if (k < 12)                      tbl[i] = 16'hFFF0;
        else if (k < 20 && (r % 2) == 1) tbl[i] = 16'hFFFF;
        else                             tbl[i] = rnd_write();
      end
      wr0 = (tbl[0] != 16'hFFFF) && (tbl[0] != 16'hFFF0);
      prep_run(0);
      pulse_start(wr0);
      wait_done($sformatf("rnd%0d", r));
    end

    // reset during the second write, then ignored start while busy
    foreach (tbl[i]) tbl[i] = 16'hFFFF;
    for (int i = 0; i < 5; i++) tbl[i] = rnd_write();
    prep_run(0);
    pulse_start(1);
    k = 0;
    while (!(sends_seen >= 2 && send) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 5000) begin
      n_checks++;
      n_fail++;
      $display("FAIL t6_reach_entry2: second write not seen within 5000 cycles (sends=%0d)", sends_seen);
    end
    abort = 1;
    reset = 1;
    @(negedge clk);
    chk("t6_rst_send", int'(send), 0);
    chk("t6_rst_busy", int'(busy), 0);
    prep_run(0);
    reset = 0;
    repeat (10) @(negedge clk);
    chk("t6_busy_before_start", int'(busy), 1);
    start = 1;
    @(negedge clk);
    start = 0;
    wait_done("t6_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
